// File: rtl/lsclk_prog.sv
// lsclk_prog - runtime-programmable low-speed clock generator.
// Divides clk by a loadable period L with a loadable high time H: each period is
// L-H cycles low followed by H cycles high. Start/stop is glitch-free (a period is
// never cut short), i_sync restarts the phase, and rise/fall strobes accompany
// every edge of o_clock. New configuration is staged in pending registers and
// only becomes active at a period boundary, on i_sync, or right away while idle.
// Optional feature macro: LSCLK_PROG_QUAD_EN adds o_clock_q, a copy of o_clock
// lagging by floor(L/4) cycles.
module lsclk_prog #(
   parameter int NB_COUNTER   = 16,
   parameter int DEFAULT_DIV  = 900,
   parameter int DEFAULT_HIGH = 450
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_enable,
   input  logic                  i_load,
   input  logic [NB_COUNTER-1:0] i_div,
   input  logic [NB_COUNTER-1:0] i_high,
   input  logic                  i_sync,
   output logic                  o_clock,
   output logic                  o_rise_tick,
   output logic                  o_fall_tick,
   output logic                  o_load_ack,
   output logic                  o_cfg_err
`ifdef LSCLK_PROG_QUAD_EN
   ,
   output logic                  o_clock_q
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [NB_COUNTER-1:0] ONE      = NB_COUNTER'(1);
   localparam logic [NB_COUNTER-1:0] TWO      = NB_COUNTER'(2);
   localparam logic [NB_COUNTER-1:0] DEF_DIV  = NB_COUNTER'(DEFAULT_DIV);
   localparam logic [NB_COUNTER-1:0] DEF_HIGH = NB_COUNTER'(DEFAULT_HIGH);

   state_t                  state_q, state_d;
   logic [NB_COUNTER-1:0]   cnt_q, cnt_d;
   logic                    clock_q, clock_d;
   logic                    rise_q, rise_d;
   logic                    fall_q, fall_d;
   logic                    ack_q, ack_d;
   logic                    err_q, err_d;
   logic [NB_COUNTER-1:0]   divAct_q, divAct_d;
   logic [NB_COUNTER-1:0]   highAct_q, highAct_d;
   logic [NB_COUNTER-1:0]   divPend_q, divPend_d;
   logic [NB_COUNTER-1:0]   highPend_q, highPend_d;
   logic                    pend_q, pend_d;

   logic                    running;
   logic                    boundary;
   logic                    riseHit;
   logic                    doSync;
   logic                    apply;
   logic                    loadValid;
   logic [NB_COUNTER-1:0]   lastCnt;
   logic [NB_COUNTER-1:0]   riseCnt;

   // Decode the events that steer the counter and the config hand-over this cycle.
   always_comb begin
      running   = (state_q != IDLE);
      lastCnt   = divAct_q - ONE;
      riseCnt   = divAct_q - highAct_q - ONE;
      boundary  = running && (cnt_q == lastCnt);
      riseHit   = running && (cnt_q == riseCnt);
      doSync    = running && i_sync;
      apply     = pend_q && (doSync || boundary || (state_q == IDLE));
      loadValid = (i_div >= TWO) && (i_high != '0) && (i_high < i_div);
   end

   // Next-state logic: FSM, period counter, output strobes and config staging.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      clock_d    = clock_q;
      rise_d     = 1'b0;
      fall_d     = 1'b0;
      ack_d      = 1'b0;
      err_d      = 1'b0;
      divAct_d   = divAct_q;
      highAct_d  = highAct_q;
      divPend_d  = divPend_q;
      highPend_d = highPend_q;
      pend_d     = pend_q;

      case (state_q)
         IDLE: begin
            cnt_d   = '0;
            clock_d = 1'b0;
            if (i_enable) begin
               state_d = RUN;
            end
         end
         RUN, DRAIN: begin
            if (doSync) begin
               cnt_d   = '0;
               clock_d = 1'b0;
               fall_d  = clock_q;
            end else if (boundary) begin
               cnt_d   = '0;
               clock_d = 1'b0;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + ONE;
               if (riseHit) begin
                  clock_d = 1'b1;
                  rise_d  = 1'b1;
               end
            end

            if (state_q == RUN) begin
               if (!i_enable) begin
                  state_d = (boundary && !doSync) ? IDLE : DRAIN;
               end
            end else begin
               if (i_enable) begin
                  state_d = RUN;
               end else if (boundary && !doSync) begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            clock_d = 1'b0;
         end
      endcase

      if (apply) begin
         divAct_d  = divPend_q;
         highAct_d = highPend_q;
         pend_d    = 1'b0;
         ack_d     = 1'b1;
      end

      if (i_load) begin
         if (loadValid) begin
            divPend_d  = i_div;
            highPend_d = i_high;
            pend_d     = 1'b1;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   // State register with synchronous reset back to the default configuration.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         clock_q    <= 1'b0;
         rise_q     <= 1'b0;
         fall_q     <= 1'b0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         divAct_q   <= DEF_DIV;
         highAct_q  <= DEF_HIGH;
         divPend_q  <= DEF_DIV;
         highPend_q <= DEF_HIGH;
         pend_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         clock_q    <= clock_d;
         rise_q     <= rise_d;
         fall_q     <= fall_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         divAct_q   <= divAct_d;
         highAct_q  <= highAct_d;
         divPend_q  <= divPend_d;
         highPend_q <= highPend_d;
         pend_q     <= pend_d;
      end
   end

   assign o_clock     = clock_q;
   assign o_rise_tick = rise_q;
   assign o_fall_tick = fall_q;
   assign o_load_ack  = ack_q;
   assign o_cfg_err   = err_q;

`ifdef LSCLK_PROG_QUAD_EN
   localparam int DEF_Q = DEFAULT_DIV / 4;
   localparam logic [NB_COUNTER-1:0] DEF_QRISE =
      NB_COUNTER'((DEFAULT_DIV - DEFAULT_HIGH - 1 + DEF_Q) % DEFAULT_DIV);
   localparam logic [NB_COUNTER-1:0] DEF_QFALL =
      NB_COUNTER'((DEFAULT_DIV - 1 + DEF_Q) % DEFAULT_DIV);
   localparam logic [NB_COUNTER:0]   ONE_W = (NB_COUNTER+1)'(1);

   logic [NB_COUNTER-1:0] qRise_q, qRise_d;
   logic [NB_COUNTER-1:0] qFall_q, qFall_d;
   logic                  clockQ_q, clockQ_d;
   logic [NB_COUNTER:0]   divW, highW, quarterW, riseSum, fallSum;

   // Lagged-clock compare points are precomputed from the pending config so the
   // running compare only needs an equality check; sums are one bit wider and
   // reduced modulo L with a single conditional subtract.
   always_comb begin
      divW     = {1'b0, divPend_q};
      highW    = {1'b0, highPend_q};
      quarterW = divW >> 2;
      riseSum  = divW - highW - ONE_W + quarterW;
      fallSum  = divW - ONE_W + quarterW;
      qRise_d  = qRise_q;
      qFall_d  = qFall_q;
      if (apply) begin
         qRise_d = (riseSum >= divW) ? NB_COUNTER'(riseSum - divW) : NB_COUNTER'(riseSum);
         qFall_d = (fallSum >= divW) ? NB_COUNTER'(fallSum - divW) : NB_COUNTER'(fallSum);
      end

      clockQ_d = clockQ_q;
      if ((state_q == IDLE) || (state_d == IDLE) || doSync) begin
         clockQ_d = 1'b0;
      end else if (cnt_q == qRise_q) begin
         clockQ_d = 1'b1;
      end else if (cnt_q == qFall_q) begin
         clockQ_d = 1'b0;
      end
   end

   // Lagged-clock registers; compare points reset to the default-config values.
   always_ff @(posedge clk) begin
      if (rst) begin
         qRise_q  <= DEF_QRISE;
         qFall_q  <= DEF_QFALL;
         clockQ_q <= 1'b0;
      end else begin
         qRise_q  <= qRise_d;
         qFall_q  <= qFall_d;
         clockQ_q <= clockQ_d;
      end
   end

   assign o_clock_q = clockQ_q;
`endif

endmodule

// File: tb/tb_lsclk_prog.sv
// tb_lsclk_prog - directed bench for lsclk_prog with hand-computed phase lengths.
// Build with +define+LSCLK_PROG_QUAD_EN to also check the lagged clock output.
module tb_lsclk_prog;

   localparam int NB = 16;

   logic          clk;
   logic          rst;
   logic          iEnable;
   logic          iLoad;
   logic [NB-1:0] iDiv;
   logic [NB-1:0] iHigh;
   logic          iSync;
   logic          o_clock;
   logic          o_rise_tick;
   logic          o_fall_tick;
   logic          o_load_ack;
   logic          o_cfg_err;
`ifdef LSCLK_PROG_QUAD_EN
   logic          o_clock_q;
`endif

   int checkCount = 0;
   int errorCount = 0;
   int tickErrs   = 0;
   logic prevClock = 1'b0;

   lsclk_prog #(
      .NB_COUNTER  (NB),
      .DEFAULT_DIV (900),
      .DEFAULT_HIGH(450)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_enable   (iEnable),
      .i_load     (iLoad),
      .i_div      (iDiv),
      .i_high     (iHigh),
      .i_sync     (iSync),
      .o_clock    (o_clock),
      .o_rise_tick(o_rise_tick),
      .o_fall_tick(o_fall_tick),
      .o_load_ack (o_load_ack),
      .o_cfg_err  (o_cfg_err)
`ifdef LSCLK_PROG_QUAD_EN
      ,
      .o_clock_q  (o_clock_q)
`endif
   );

   // Free-running system clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the design never lets the stimulus make progress.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Counts one comparison and reports it when the values differ.
   task automatic checkOutput(input string tag, input int actual, input int expected);
      checkCount++;
      if (actual != expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
      end
   endtask

   // Advances one clock and samples 1 unit after the edge; ticks must mark edges of o_clock.
   task automatic tick();
      @(posedge clk);
      #1;
      if (o_rise_tick !== (o_clock && !prevClock)) tickErrs++;
      if (o_fall_tick !== (!o_clock && prevClock)) tickErrs++;
      prevClock = o_clock;
   endtask

   // Drives one cycle of load/sync strobes with the given config, then releases them.
   task automatic applyStimulus(input logic load, input int div, input int high, input logic sync);
      iLoad = load;
      iDiv  = NB'(div);
      iHigh = NB'(high);
      iSync = sync;
      tick();
      iLoad = 1'b0;
      iSync = 1'b0;
   endtask

   // Counts consecutive samples at the given level; stops on change or after 2000 cycles.
   task automatic measurePhase(input logic level, output int len);
      len = 0;
      while ((o_clock == level) && (len < 2000)) begin
         len++;
         tick();
      end
   endtask

   initial begin
      int len;
      int highs;
      rst     = 1'b1;
      iEnable = 1'b0;
      iLoad   = 1'b0;
      iDiv    = '0;
      iHigh   = '0;
      iSync   = 1'b0;

      // Reset state.
      repeat (3) tick();
      checkOutput("rstClock", o_clock, 0);
      checkOutput("rstRise", o_rise_tick, 0);
      checkOutput("rstFall", o_fall_tick, 0);
      checkOutput("rstAck", o_load_ack, 0);
      checkOutput("rstErr", o_cfg_err, 0);
      rst = 1'b0;
      tick();
      checkOutput("idleClock", o_clock, 0);

      // Default 900/450 run.
      iEnable = 1'b1;
      tick();
      measurePhase(1'b0, len); checkOutput("defLow", len, 450);
      checkOutput("defRiseTick", o_rise_tick, 1);
      measurePhase(1'b1, len); checkOutput("defHigh", len, 450);
      checkOutput("defFallTick", o_fall_tick, 1);

      // Three invalid loads at cnt 0..2; active period must stay 900.
      applyStimulus(1'b1, 1, 1, 1'b0); checkOutput("errDiv1", o_cfg_err, 1);
      applyStimulus(1'b1, 8, 8, 1'b0); checkOutput("errHighEqDiv", o_cfg_err, 1);
      applyStimulus(1'b1, 8, 0, 1'b0); checkOutput("errHigh0", o_cfg_err, 1);
      tick();
      checkOutput("errPulseEnd", o_cfg_err, 0);
      checkOutput("errNoAck", o_load_ack, 0);
      measurePhase(1'b0, len); checkOutput("errLowRest", len, 446);

      // Mid-period load of 10/3 at cnt 450; applied only at the boundary.
      applyStimulus(1'b1, 10, 3, 1'b0);
      checkOutput("midLoadNoAck", o_load_ack, 0);
      checkOutput("midLoadNoErr", o_cfg_err, 0);
      measurePhase(1'b1, len); checkOutput("midHighRest", len, 449);
      checkOutput("midAck", o_load_ack, 1);
      measurePhase(1'b0, len); checkOutput("p10Low", len, 7);
      checkOutput("ackOneCycle", o_load_ack, 0);
      measurePhase(1'b1, len); checkOutput("p10High", len, 3);
      measurePhase(1'b0, len); checkOutput("p10Low2", len, 7);
      measurePhase(1'b1, len); checkOutput("p10High2", len, 3);

      // Drop enable during the high phase: the period finishes, then stays idle.
      measurePhase(1'b0, len); checkOutput("drainLow", len, 7);
      iEnable = 1'b0;
      tick();
      measurePhase(1'b1, len); checkOutput("drainHighRest", len, 2);
      highs = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (o_clock) highs++;
      end
      checkOutput("idleNoHigh", highs, 0);

      // Drop and re-raise enable within a period: no gap.
      iEnable = 1'b1;
      tick();
      measurePhase(1'b0, len); checkOutput("reLow", len, 7);
      iEnable = 1'b0;
      tick();
      iEnable = 1'b1;
      tick();
      measurePhase(1'b1, len); checkOutput("reHighRest", len, 1);
      measurePhase(1'b0, len); checkOutput("reLow2", len, 7);
      measurePhase(1'b1, len); checkOutput("reHigh2", len, 3);

      // Sync while high at cnt 8.
      measurePhase(1'b0, len); checkOutput("preSyncLow", len, 7);
      tick();
      applyStimulus(1'b0, 0, 0, 1'b1);
      checkOutput("syncClock", o_clock, 0);
      checkOutput("syncFall", o_fall_tick, 1);
      measurePhase(1'b0, len); checkOutput("syncLow", len, 7);
      measurePhase(1'b1, len); checkOutput("syncHigh", len, 3);

      // Sync while low at cnt 2: no fall tick, low phase restarts.
      tick();
      tick();
      applyStimulus(1'b0, 0, 0, 1'b1);
      checkOutput("syncLowFall", o_fall_tick, 0);
      measurePhase(1'b0, len); checkOutput("syncLowRestart", len, 7);

      // Load 8/4 at cnt 7 of a 10-period.
      applyStimulus(1'b1, 8, 4, 1'b0);
      measurePhase(1'b1, len); checkOutput("p8PrevHigh", len, 2);
      checkOutput("p8Ack", o_load_ack, 1);
      measurePhase(1'b0, len); checkOutput("p8Low", len, 4);
      measurePhase(1'b1, len); checkOutput("p8High", len, 4);
`ifdef LSCLK_PROG_QUAD_EN
      // Lagged clock: high on cnt 6,7,0,1, i.e. o_clock delayed by 2.
      for (int i = 0; i < 16; i++) begin
         int k;
         k = i % 8;
         checkOutput("quadMain", o_clock, (k >= 4) ? 1 : 0);
         checkOutput("quadLag", o_clock_q, (k <= 1 || k >= 6) ? 1 : 0);
         tick();
      end
`else
      repeat (16) tick();
`endif

      // Stop, then load 6/2 while idle: applied in the cycle after capture.
      iEnable = 1'b0;
      repeat (20) tick();
      checkOutput("stopClock", o_clock, 0);
      applyStimulus(1'b1, 6, 2, 1'b0);
      checkOutput("idleCaptureNoAck", o_load_ack, 0);
      tick();
      checkOutput("idleAck", o_load_ack, 1);
      iEnable = 1'b1;
      tick();
      measurePhase(1'b0, len); checkOutput("p6Low", len, 4);
      tick();

      // Load 4/1 in the boundary cycle: pending until the following boundary.
      applyStimulus(1'b1, 4, 1, 1'b0);
      checkOutput("bndNoAck", o_load_ack, 0);
      checkOutput("bndFall", o_fall_tick, 1);
      measurePhase(1'b0, len); checkOutput("bndOldLow", len, 4);
      measurePhase(1'b1, len); checkOutput("bndOldHigh", len, 2);
      checkOutput("bndAck", o_load_ack, 1);
      measurePhase(1'b0, len); checkOutput("p4Low", len, 3);
      measurePhase(1'b1, len); checkOutput("p4High", len, 1);

      checkOutput("tickConsistency", tickErrs, 0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/lsclk_prog.md
Name: lsclk_prog

Overview:
- Runtime-programmable low-speed clock generator; the parametrised successor of the fixed-limit counter divider.
- Divides clk by a loadable period with a loadable high time, so duty cycle is not fixed at 50 %.
- Supports gated start/stop without glitches, phase resynchronisation, and rise/fall strobes.
- Drives sampling and PWM timing for the filter datapath.

Parameters:
- NB_COUNTER, 16, width of period counter and config words.
- DEFAULT_DIV, 900, period in clk cycles loaded at reset (must be >= 2).
- DEFAULT_HIGH, 450, high time in clk cycles loaded at reset (1..DEFAULT_DIV-1).

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- i_enable  in  1  level; run the generator.
- i_load  in  1  one-cycle strobe; capture i_div/i_high as pending config.
- i_div  in  NB_COUNTER  requested period.
- i_high  in  NB_COUNTER  requested high time.
- i_sync  in  1  one-cycle strobe; restart the period at phase 0.
- o_clock  out  1  generated clock (registered).
- o_rise_tick  out  1  one-cycle pulse in the first cycle o_clock is high.
- o_fall_tick  out  1  one-cycle pulse in the first cycle o_clock is low after high.
- o_load_ack  out  1  one-cycle pulse when pending config becomes active.
- o_cfg_err  out  1  one-cycle pulse when i_load carried an invalid config.

Behaviour:
- Reset: o_clock, all ticks, o_load_ack and o_cfg_err = 0; cnt = 0; state IDLE; div_act = DEFAULT_DIV; high_act = DEFAULT_HIGH; pending flag cleared.
- Active config is L = div_act, H = high_act. All outputs are registered; no combinational path from inputs to outputs.
- FSM states are IDLE, RUN and DRAIN.
  - IDLE: cnt held at 0, o_clock = 0. i_enable=1 -> RUN at the next edge; cnt counts from 0 in the first RUN cycle.
  - RUN: cnt increments each cycle.
    - Edge with cnt == L-H-1: o_clock <= 1 and o_rise_tick <= 1.
    - Edge with cnt == L-1 (period boundary): o_clock <= 0, o_fall_tick <= 1, cnt <= 0.
    - Result: L-H cycles low, then H cycles high, period exactly L.
    - i_enable=0 -> DRAIN.
  - DRAIN: counting continues unchanged until the period boundary, then -> IDLE. A period is never truncated.
    - i_enable=1 while in DRAIN -> RUN with no phase disturbance.
- Config load (i_load=1):
  - Valid when i_div >= 2 and 1 <= i_high <= i_div-1.
  - Valid load: the value goes to the pending registers and the pending flag is set. A later load before application overwrites the pending value (last wins).
  - Invalid load: o_cfg_err pulses at the next edge; pending and active config are unchanged.
- Config application: at the period boundary, at i_sync, or in the cycle after capture when in IDLE. Application copies pending to active, clears the pending flag and pulses o_load_ack. The new L/H govern the very next period.
- i_sync (RUN or DRAIN): next edge sets cnt <= 0 and o_clock <= 0; o_fall_tick pulses only if o_clock was 1; pending config is applied. i_sync is ignored in IDLE.
- Priority: rst > i_sync > period boundary > i_enable deassertion.
- i_load in the same cycle as a boundary: the value captured in that cycle is pending for the following boundary. It is not applied in that cycle.
- cnt never exceeds L-1; comparisons use NB_COUNTER-bit unsigned arithmetic; no wrap beyond L-1.

Optional Feature:
- Macro LSCLK_PROG_QUAD_EN.
- Defined: adds output o_clock_q (1 bit) with the same L and H as o_clock, lagging it by Q = floor(L/4) cycles.
  - Rise compare value: (L-H-1+Q) mod L. Fall compare value: (L-1+Q) mod L.
  - Both compare values are precomputed into registers when config is applied.
  - o_clock_q is forced to 0 in IDLE, after reset and after i_sync.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, i_enable=1, default config -> o_clock low 450 cycles, high 450, period 900; o_rise_tick and o_fall_tick each one cycle per period.
- Mid-period i_load with div=10, high=3 -> current 900-cycle period completes; o_load_ack pulses at the boundary; then 7 low / 3 high repeating.
- i_load with div=1, then div=8 high=8, then div=8 high=0 -> o_cfg_err pulses 3 times; the period stays 900.
- div=10 high=3 running; drop i_enable during the high phase -> period finishes, o_clock=0, state IDLE. Second run: drop and re-raise i_enable within the period -> no gap, period stays 10.
- div=10 running; i_sync at cnt=8 (o_clock high) -> next cycle o_clock=0 and o_fall_tick=1; next rise 7 cycles later.
- LSCLK_PROG_QUAD_EN, div=8 high=4 -> o_clock_q is the same waveform as o_clock delayed by exactly 2 cycles.
